// File: rtl/coin_panel_controller_if.sv
// Panel and washer signal bundle for the coin panel controller.
// The slave modport is the controller side; the master modport is the panel/washer side.
interface coin_panel_controller_if #(
    parameter int CW = 3
) ();
    // Panel inputs
    logic          coin_in;
    logic          btn_mode1;
    logic          btn_mode2;
    logic          btn_mode3;
    logic          btn_cancel;
    // Washer status inputs (one-hot)
    logic          idle_op;
    logic          ready_op;
    logic          soak_op;
    logic          wash_op;
    logic          rinse_op;
    logic          spin_op;
    // Washer control and panel status outputs
    logic          start;
    logic          cancel;
    logic          mode1;
    logic          mode2;
    logic          mode3;
    logic [CW-1:0] credit;
    logic          coin_refund;
    logic          coin_reject;
    logic          busy;
    logic          cycle_done;
    logic          cycle_abort;
    logic          fault;

    modport slave (
        input  coin_in, btn_mode1, btn_mode2, btn_mode3, btn_cancel,
        input  idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op,
        output start, cancel, mode1, mode2, mode3, credit,
        output coin_refund, coin_reject, busy, cycle_done, cycle_abort, fault
    );

    modport master (
        output coin_in, btn_mode1, btn_mode2, btn_mode3, btn_cancel,
        output idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op,
        input  start, cancel, mode1, mode2, mode3, credit,
        input  coin_refund, coin_reject, busy, cycle_done, cycle_abort, fault
    );
endinterface

// File: rtl/coin_panel_controller.sv
// Laundromat front panel: counts coins, latches the wash mode, sequences the
// start/mode/cancel handshake with the washer and refunds unused credit.
module coin_panel_controller #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int CW         = 3,
    parameter int TIMEOUT    = 1000,
    parameter int TW         = 10
) (
    input logic                    clk,
    input logic                    rst,
    coin_panel_controller_if.slave bus
);

    typedef enum logic [2:0] {
        P_IDLE, P_ARM, P_SELECT, P_CANCEL, P_REFUND, P_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [2:0]    mode_q, mode_d;
    logic          pend_q, pend_d;
    logic          spin_q, spin_d;
    logic          phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          reject_d, refund_d, done_d, abort_d, fault_d;
    logic          start_q, cancel_q, busy_q;
    logic          reject_q, refund_q, done_q, abort_q, fault_q;
    logic [2:0]    mode_o_q;

    logic          mode_req, timed_out, has_credit, run_idle;

    assign mode_req   = bus.btn_mode1 | bus.btn_mode2 | bus.btn_mode3;
    assign timed_out  = (timer_q == TW'(TIMEOUT - 1));
    assign has_credit = (credit_q != '0);
    // Washer status is one-hot; idle ends a run only when no running phase is flagged.
    assign run_idle   = bus.idle_op & ~(bus.soak_op | bus.wash_op | bus.rinse_op | bus.spin_op);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= P_IDLE;
            credit_q <= '0;
            mode_q   <= '0;
            pend_q   <= 1'b0;
            spin_q   <= 1'b0;
            phase_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            spin_q   <= spin_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
        end
    end

    // Next-state, credit bookkeeping and pulse requests.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        spin_d   = spin_q;
        phase_d  = 1'b0;
        timer_d  = '0;
        reject_d = 1'b0;
        refund_d = 1'b0;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            P_IDLE: begin
                if (bus.coin_in) begin
                    if (credit_q == CW'(MAX_CREDIT)) reject_d = 1'b1;
                    else                             credit_d = credit_q + 1'b1;
                end
                if (bus.btn_cancel && has_credit) begin
                    state_d = P_REFUND;
                end else if (credit_q >= CW'(PRICE) && bus.idle_op && mode_req) begin
                    mode_d  = bus.btn_mode1 ? 3'b001 : (bus.btn_mode2 ? 3'b010 : 3'b100);
                    pend_d  = 1'b0;
                    state_d = P_ARM;
                end
            end
            P_ARM: begin
                reject_d = bus.coin_in;
                pend_d   = pend_q | bus.btn_cancel;
                if (bus.ready_op) begin
                    state_d = (pend_q | bus.btn_cancel) ? P_CANCEL : P_SELECT;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    state_d = has_credit ? P_REFUND : P_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            P_SELECT: begin
                reject_d = bus.coin_in;
                if (bus.btn_cancel) begin
                    state_d = P_CANCEL;
                end else if (!bus.ready_op) begin
                    credit_d = credit_q - CW'(PRICE);
                    spin_d   = 1'b0;
                    state_d  = P_RUN;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    state_d = has_credit ? P_REFUND : P_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            P_CANCEL: begin
                reject_d = bus.coin_in;
                if (!bus.ready_op) state_d = has_credit ? P_REFUND : P_IDLE;
            end
            P_REFUND: begin
                reject_d = bus.coin_in;
                // phase_q is 0 on entry, so the first refund shows one cycle after entry.
                if (!has_credit) begin
                    state_d = P_IDLE;
                end else if (!phase_q) begin
                    refund_d = 1'b1;
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CW'(1)) state_d = P_IDLE;
                    else                    phase_d = 1'b1;
                end
            end
            P_RUN: begin
                reject_d = bus.coin_in;
                spin_d   = spin_q | bus.spin_op;
                if (run_idle) begin
                    done_d  = spin_q | bus.spin_op;
                    abort_d = ~(spin_q | bus.spin_op);
                    state_d = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state so they track the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q  <= 1'b0;
            cancel_q <= 1'b0;
            mode_o_q <= '0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
            refund_q <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            start_q  <= (state_d == P_ARM);
            cancel_q <= (state_d == P_CANCEL);
            mode_o_q <= (state_d == P_SELECT) ? mode_d : '0;
            busy_q   <= (state_d != P_IDLE);
            reject_q <= reject_d;
            refund_q <= refund_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.start       = start_q;
    assign bus.cancel      = cancel_q;
    assign bus.mode1       = mode_o_q[0];
    assign bus.mode2       = mode_o_q[1];
    assign bus.mode3       = mode_o_q[2];
    assign bus.credit      = credit_q;
    assign bus.coin_refund = refund_q;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = busy_q;
    assign bus.cycle_done  = done_q;
    assign bus.cycle_abort = abort_q;
    assign bus.fault       = fault_q;

endmodule
